// File: rtl/tone_envelope_pwm.sv
// Waveform shaper, gated ADSR envelope and 1-bit audio output stage for the phase-accumulator tone generator.
// Define TONE_SIGMA_DELTA_EN to replace the counter PWM with a first-order sigma-delta modulator.
module tone_envelope_pwm #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] phase_in,
  input  logic [1:0] wave_sel,
  input  logic       gate,
  input  logic [3:0] attack_rate,
  input  logic [3:0] decay_rate,
  input  logic [3:0] sustain_lvl,
  input  logic [3:0] release_rate,
  output logic [7:0] sample_out,
  output logic [7:0] env_out,
  output logic [2:0] env_state,
  output logic       pwm_out
);

  localparam int unsigned RATE_W = 15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } env_state_t;

  env_state_t            state, state_nxt;
  logic [7:0]            env, env_nxt;
  logic [PRESCALE_W-1:0] presc;
  logic [RATE_W-1:0]     rate_cnt, rate_cnt_nxt;
  logic                  gate_q;
  logic [7:0]            wave_reg, wave_c;
  logic                  rise_c, fall_c, tick_c, step_c;
  logic [3:0]            rate_c;
  logic [RATE_W-1:0]     rate_max_c;
  logic [7:0]            sus_c;
  logic [15:0]           prod_c;

  assign env_out   = env;
  assign env_state = state;

  // Waveform selection from the phase byte
  always_comb begin
    wave_c = phase_in;
    case (wave_sel)
      2'b00:   wave_c = phase_in;
      2'b01:   wave_c = {8{phase_in[7]}};
      2'b10:   wave_c = phase_in[7] ? ~{phase_in[6:0], 1'b0} : {phase_in[6:0], 1'b0};
      default: wave_c = (phase_in[7:6] == 2'b11) ? 8'hFF : 8'h00;
    endcase
  end

  assign prod_c     = 16'(wave_reg) * 16'(env);
  assign rise_c     = gate & ~gate_q;
  assign fall_c     = ~gate & gate_q;
  assign tick_c     = &presc;
  assign sus_c      = {sustain_lvl, sustain_lvl};
  assign rate_max_c = RATE_W'((16'd1 << rate_c) - 16'd1);
  assign step_c     = tick_c && (rate_cnt == rate_max_c);

  always_comb begin
    rate_c = 4'd0;
    case (state)
      S_ATTACK:  rate_c = attack_rate;
      S_DECAY:   rate_c = decay_rate;
      S_RELEASE: rate_c = release_rate;
      default:   rate_c = 4'd0;
    endcase
  end

  // Envelope next-state; a state change always pre-empts a step in the same cycle
  always_comb begin
    state_nxt    = state;
    env_nxt      = env;
    rate_cnt_nxt = rate_cnt;
    case (state)
      S_IDLE: begin
        env_nxt = 8'd0;
        if (rise_c) state_nxt = S_ATTACK;
      end
      S_ATTACK: begin
        if (fall_c)              state_nxt = S_RELEASE;
        else if (env == 8'hFF)   state_nxt = S_DECAY;
        else if (step_c)         env_nxt   = env + 8'd1;
      end
      S_DECAY: begin
        if (fall_c)              state_nxt = S_RELEASE;
        else if (env <= sus_c)   state_nxt = S_SUSTAIN;
        else if (step_c)         env_nxt   = env - 8'd1;
      end
      S_SUSTAIN: begin
        if (fall_c)              state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (rise_c)              state_nxt = S_ATTACK;
        else if (env == 8'h00)   state_nxt = S_IDLE;
        else if (step_c)         env_nxt   = env - 8'd1;
      end
      default: begin
        state_nxt = S_IDLE;
        env_nxt   = 8'd0;
      end
    endcase
    if ((state_nxt != state) || step_c) rate_cnt_nxt = '0;
    else if (tick_c)                    rate_cnt_nxt = rate_cnt + RATE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      env        <= 8'd0;
      presc      <= '0;
      rate_cnt   <= '0;
      gate_q     <= 1'b0;
      wave_reg   <= 8'd0;
      sample_out <= 8'd0;
    end else begin
      state      <= state_nxt;
      env        <= env_nxt;
      presc      <= presc + PRESCALE_W'(1);
      rate_cnt   <= rate_cnt_nxt;
      gate_q     <= gate;
      wave_reg   <= wave_c;
      sample_out <= prod_c[15:8];
    end
  end

`ifdef TONE_SIGMA_DELTA_EN
  logic [7:0] sd_acc;
  logic [8:0] sd_sum_c;

  // First-order sigma-delta: carry out of the accumulator is the output bit
  assign sd_sum_c = {1'b0, sd_acc} + {1'b0, sample_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_acc  <= 8'd0;
      pwm_out <= 1'b0;
    end else begin
      sd_acc  <= sd_sum_c[7:0];
      pwm_out <= sd_sum_c[8];
    end
  end
`else
  logic [7:0] pwm_cnt;
  logic [7:0] duty;

  // Duty reloads only at period end so each 256-cycle period is whole
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
      duty    <= 8'd0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) duty <= sample_out;
      pwm_out <= (pwm_cnt < duty);
    end
  end
`endif

endmodule

// File: tb/tb_tone_envelope_pwm.sv
// Directed self-checking bench for tone_envelope_pwm (PRESCALE_W=2, envelope tick every 4 clk).
module tb_tone_envelope_pwm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] phase_in = 8'd0;
  logic [1:0] wave_sel = 2'd0;
  logic       gate = 1'b0;
  logic [3:0] attack_rate = 4'd0;
  logic [3:0] decay_rate = 4'd0;
  logic [3:0] sustain_lvl = 4'd8;
  logic [3:0] release_rate = 4'd0;
  logic [7:0] sample_out;
  logic [7:0] env_out;
  logic [2:0] env_state;
  logic       pwm_out;

  int tests = 0;
  int fails = 0;

  tone_envelope_pwm #(.PRESCALE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .phase_in(phase_in), .wave_sel(wave_sel), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate), .sustain_lvl(sustain_lvl),
    .release_rate(release_rate), .sample_out(sample_out), .env_out(env_out),
    .env_state(env_state), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (env_state == s) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic wait_env(input logic [7:0] v, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (env_out == v) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    tests++; if (sample_out !== 8'd0) begin fails++; $display("FAIL reset_sample got %0d want 0", sample_out); end
    tests++; if (env_out !== 8'd0) begin fails++; $display("FAIL reset_env got %0d want 0", env_out); end
    tests++; if (env_state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", env_state); end
    tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL reset_pwm got %0b want 0", pwm_out); end
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    tests++; if (env_state !== 3'd0) begin fails++; $display("FAIL idle_after_reset got %0d want 0", env_state); end
  endtask

  task automatic test_attack_decay_sustain;
    bit ok;
    attack_rate = 4'd0; decay_rate = 4'd0; release_rate = 4'd0; sustain_lvl = 4'd8;
    gate = 1'b1;
    cyc(2);
    tests++; if (env_state !== 3'd1) begin fails++; $display("FAIL attack_entry got %0d want 1", env_state); end
    wait_state(3'd2, 1500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL reach_decay got state %0d want 2", env_state); end
    tests++; if (env_out !== 8'd255) begin fails++; $display("FAIL attack_peak got %0d want 255", env_out); end
    wait_state(3'd3, 1500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL reach_sustain got state %0d want 3", env_state); end
    tests++; if (env_out !== 8'h88) begin fails++; $display("FAIL sustain_level got %0d want 136", env_out); end
    cyc(20);
    tests++; if (env_out !== 8'd136 || env_state !== 3'd3) begin
      fails++; $display("FAIL sustain_hold got env %0d state %0d want 136/3", env_out, env_state);
    end
  endtask

  task automatic test_release_retrigger;
    bit ok;
    logic [7:0] prev;
    int n;
    release_rate = 4'd1;
    gate = 1'b0;
    cyc(1);
    tests++; if (env_state !== 3'd4) begin fails++; $display("FAIL release_entry got %0d want 4", env_state); end
    prev = env_out;
    for (int i = 0; i < 50 && env_out == prev; i++) cyc(1);
    prev = env_out;
    n = 0;
    for (int i = 0; i < 50 && env_out == prev; i++) begin cyc(1); n++; end
    tests++; if (n != 8) begin fails++; $display("FAIL release_interval got %0d want 8", n); end
    tests++; if (env_out !== prev - 8'd1) begin fails++; $display("FAIL release_step got %0d want %0d", env_out, prev - 8'd1); end
    wait_env(8'd50, 1500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL release_to_50 got %0d want 50", env_out); end
    sustain_lvl = 4'hF;
    gate = 1'b1;
    cyc(1);
    tests++; if (env_state !== 3'd1 || env_out !== 8'd50) begin
      fails++; $display("FAIL retrigger got state %0d env %0d want 1/50", env_state, env_out);
    end
    wait_env(8'd51, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL retrigger_up got %0d want 51", env_out); end
  endtask

  task automatic test_sustain_full;
    bit ok;
    int n;
    wait_state(3'd2, 1500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL full_reach_decay got state %0d want 2", env_state); end
    n = 0;
    while (env_state == 3'd2 && n < 10) begin n++; cyc(1); end
    tests++; if (n != 1) begin fails++; $display("FAIL decay_one_cycle got %0d want 1", n); end
    tests++; if (env_state !== 3'd3 || env_out !== 8'd255) begin
      fails++; $display("FAIL full_sustain got state %0d env %0d want 3/255", env_state, env_out);
    end
  endtask

  task automatic test_waveforms;
    logic [1:0] sel_t [8] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3};
    logic [7:0] ph_t  [8] = '{8'h40, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0};
    logic [7:0] exp_t [8] = '{8'd63, 8'd191, 8'd127, 8'd126, 8'd0, 8'd254, 8'd0, 8'd254};
    wave_sel = 2'd0; phase_in = 8'h40;
    cyc(2);
    phase_in = 8'hC0;
    cyc(1);
    tests++; if (sample_out !== 8'd63) begin fails++; $display("FAIL latency_hold got %0d want 63", sample_out); end
    cyc(1);
    tests++; if (sample_out !== 8'd191) begin fails++; $display("FAIL latency_two got %0d want 191", sample_out); end
    for (int i = 0; i < 8; i++) begin
      wave_sel = sel_t[i]; phase_in = ph_t[i];
      cyc(2);
      tests++; if (sample_out !== exp_t[i]) begin
        fails++; $display("FAIL wave sel %0d phase %h got %0d want %0d", sel_t[i], ph_t[i], sample_out, exp_t[i]);
      end
    end
  endtask

  task automatic count_ones(output int ones, output int max_run);
    int run;
    ones = 0; max_run = 0; run = 0;
    repeat (256) begin
      if (pwm_out) begin ones++; run++; if (run > max_run) max_run = run; end
      else run = 0;
      cyc(1);
    end
  endtask

  task automatic test_pwm;
    int ones, max_run;
    wave_sel = 2'd0; phase_in = 8'd65;
    cyc(600);
    tests++; if (sample_out !== 8'd64) begin fails++; $display("FAIL pwm_sample got %0d want 64", sample_out); end
    count_ones(ones, max_run);
    tests++; if (ones != 64) begin fails++; $display("FAIL pwm_density got %0d want 64", ones); end
`ifdef TONE_SIGMA_DELTA_EN
    tests++; if (max_run != 1) begin fails++; $display("FAIL sd_run got %0d want 1", max_run); end
`endif
    phase_in = 8'd0;
    cyc(600);
    count_ones(ones, max_run);
    tests++; if (ones != 0) begin fails++; $display("FAIL pwm_zero got %0d want 0", ones); end
  endtask

  task automatic test_release_to_idle;
    logic [7:0] prev;
    bit bad, ok;
    release_rate = 4'd0;
    gate = 1'b0;
    prev = env_out; bad = 1'b0; ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      cyc(1);
      if (env_out > prev) bad = 1'b1;
      prev = env_out;
      if (env_state == 3'd0) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL reach_idle got state %0d want 0", env_state); end
    tests++; if (bad) begin fails++; $display("FAIL release_monotonic got rise want none"); end
    cyc(10);
    tests++; if (env_out !== 8'd0 || env_state !== 3'd0) begin
      fails++; $display("FAIL idle_floor got env %0d state %0d want 0/0", env_out, env_state);
    end
  endtask

  task automatic test_sustain_zero;
    bit ok;
    sustain_lvl = 4'd0;
    gate = 1'b1;
    wait_state(3'd2, 1500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL zero_reach_decay got state %0d want 2", env_state); end
    wait_state(3'd3, 1500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL zero_reach_sustain got state %0d want 3", env_state); end
    cyc(20);
    tests++; if (env_state !== 3'd3 || env_out !== 8'd0) begin
      fails++; $display("FAIL zero_sustain got state %0d env %0d want 3/0", env_state, env_out);
    end
  endtask

  task automatic test_reset_mid_note;
    bit ok;
    gate = 1'b0;
    wait_state(3'd0, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_pre_idle got state %0d want 0", env_state); end
    phase_in = 8'hC0; wave_sel = 2'd1;
    gate = 1'b1;
    wait_env(8'd100, 800, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_reach_100 got %0d want 100", env_out); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (sample_out !== 8'd0 || env_out !== 8'd0 || env_state !== 3'd0 || pwm_out !== 1'b0) begin
      fails++; $display("FAIL mid_reset got sample %0d env %0d state %0d pwm %0b want all 0",
                        sample_out, env_out, env_state, pwm_out);
    end
    gate = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    tests++; if (env_state !== 3'd0 || env_out !== 8'd0) begin
      fails++; $display("FAIL mid_post_reset got state %0d env %0d want 0/0", env_state, env_out);
    end
  endtask

  initial begin
    test_reset();
    test_attack_decay_sustain();
    test_release_retrigger();
    test_sustain_full();
    test_waveforms();
    test_pwm();
    test_release_to_idle();
    test_sustain_zero();
    test_reset_mid_note();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
